// File: rtl/exe_forward_source_pkg.sv
// rtl/exe_forward_source_pkg.sv - shared widths, stage-entry type and hazard helper for the forwarding source
package exe_forward_source_pkg;

    localparam int DW = 32;
    localparam int RW = 5;

    typedef struct packed {
        logic          valid;
        logic          we;
        logic          late;
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
    } stage_t;

    // True when src reads a register whose value is still pending in exe2.
    function automatic logic late_hit(input logic [RW-1:0] src, input stage_t s);
        return (src != '0) && s.valid && s.we && s.late && (s.rd == src);
    endfunction

endpackage

// File: rtl/exe_forward_source_fwd_stage_reg.sv
// rtl/exe_forward_source_fwd_stage_reg.sv - one EU's exe1/exe2 boundary register pair
module fwd_stage_reg
    import exe_forward_source_pkg::*;
(
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          hold,
    input  stage_t        s0_next,
    input  logic [DW-1:0] e2_data,
    output stage_t        s0,
    output stage_t        s1
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s0 <= '0;
            s1 <= '0;
        end else if (flush) begin
            s0.valid <= 1'b0;
            s1.valid <= 1'b0;
        end else if (!hold) begin
            // Late ops pick up their real result as they cross into exe2.
            s1       <= s0;
            s1.data  <= s0.late ? e2_data : s0.data;
            s0       <= s0_next;
        end
    end

endmodule

// File: rtl/exe_forward_source.sv
// rtl/exe_forward_source.sv - dual-issue forward producer: stage registers, forward tuples and issue gating
module exe_forward_source
    import exe_forward_source_pkg::*;
(
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          hold,
    input  logic          i0_valid,
    input  logic          i1_valid,
    input  logic [RW-1:0] i0_rd,
    input  logic [RW-1:0] i1_rd,
    input  logic          i0_we,
    input  logic          i1_we,
    input  logic          i0_late,
    input  logic          i1_late,
    input  logic [RW-1:0] i0_rj,
    input  logic [RW-1:0] i0_rk,
    input  logic [RW-1:0] i1_rj,
    input  logic [RW-1:0] i1_rk,
    input  logic [DW-1:0] e1_data0,
    input  logic [DW-1:0] e1_data1,
    input  logic [DW-1:0] e2_data0,
    input  logic [DW-1:0] e2_data1,
    output logic          i0_accept,
    output logic          i1_accept,
    output logic          eu0_en_0,
    output logic          eu1_en_0,
    output logic [RW-1:0] eu0_rd_0,
    output logic [RW-1:0] eu1_rd_0,
    output logic [DW-1:0] data_forward00,
    output logic [DW-1:0] data_forward10,
    output logic          eu0_en_1,
    output logic          eu1_en_1,
    output logic [RW-1:0] eu0_rd_1,
    output logic [RW-1:0] eu1_rd_1,
    output logic [DW-1:0] data_forward01,
    output logic [DW-1:0] data_forward11
);

    stage_t eu0_next, eu1_next;
    stage_t eu0_s0, eu0_s1, eu1_s0, eu1_s1;
    logic   i0_loaduse, i1_loaduse, pair_hazard;

    assign i0_loaduse = late_hit(i0_rj, eu0_s0) | late_hit(i0_rj, eu1_s0)
                      | late_hit(i0_rk, eu0_s0) | late_hit(i0_rk, eu1_s0);
    assign i1_loaduse = late_hit(i1_rj, eu0_s0) | late_hit(i1_rj, eu1_s0)
                      | late_hit(i1_rk, eu0_s0) | late_hit(i1_rk, eu1_s0);

    // i1 cannot see i0's result in the same cycle, so any intra-pair RAW splits the pair.
    assign pair_hazard = i0_valid & i0_we &
                         (((i1_rj != '0) && (i1_rj == i0_rd)) ||
                          ((i1_rk != '0) && (i1_rk == i0_rd)));

    assign i0_accept = i0_valid & ~hold & ~i0_loaduse;
    assign i1_accept = i1_valid & i0_accept & ~i1_loaduse & ~pair_hazard;

    always_comb begin
        eu0_next = '{valid: i0_accept, we: i0_we, late: i0_late, rd: i0_rd, data: e1_data0};
        eu1_next = '{valid: i1_accept, we: i1_we, late: i1_late, rd: i1_rd, data: e1_data1};
    end

    fwd_stage_reg u_eu0 (
        .clk     (clk),
        .rstn    (rstn),
        .flush   (flush),
        .hold    (hold),
        .s0_next (eu0_next),
        .e2_data (e2_data0),
        .s0      (eu0_s0),
        .s1      (eu0_s1)
    );

    fwd_stage_reg u_eu1 (
        .clk     (clk),
        .rstn    (rstn),
        .flush   (flush),
        .hold    (hold),
        .s0_next (eu1_next),
        .e2_data (e2_data1),
        .s0      (eu1_s0),
        .s1      (eu1_s1)
    );

    // A late op's exe1 data is not a result yet, so it only forwards from exe2.
    assign eu0_en_0 = eu0_s0.valid & eu0_s0.we & ~eu0_s0.late & (eu0_s0.rd != '0);
    assign eu1_en_0 = eu1_s0.valid & eu1_s0.we & ~eu1_s0.late & (eu1_s0.rd != '0);
    assign eu0_en_1 = eu0_s1.valid & eu0_s1.we & (eu0_s1.rd != '0);
    assign eu1_en_1 = eu1_s1.valid & eu1_s1.we & (eu1_s1.rd != '0);

    assign eu0_rd_0       = eu0_s0.rd;
    assign eu1_rd_0       = eu1_s0.rd;
    assign eu0_rd_1       = eu0_s1.rd;
    assign eu1_rd_1       = eu1_s1.rd;
    assign data_forward00 = eu0_s0.data;
    assign data_forward10 = eu1_s0.data;
    assign data_forward01 = eu0_s1.data;
    assign data_forward11 = eu1_s1.data;

endmodule

// File: tb/tb_exe_forward_source.sv
// tb/tb_exe_forward_source.sv - directed self-checking bench for exe_forward_source
module tb_exe_forward_source;

    logic        clk = 1'b0;
    logic        rstn, flush, hold;
    logic        i0_valid, i1_valid, i0_we, i1_we, i0_late, i1_late;
    logic [4:0]  i0_rd, i1_rd, i0_rj, i0_rk, i1_rj, i1_rk;
    logic [31:0] e1_data0, e1_data1, e2_data0, e2_data1;
    logic        i0_accept, i1_accept;
    logic        eu0_en_0, eu1_en_0, eu0_en_1, eu1_en_1;
    logic [4:0]  eu0_rd_0, eu1_rd_0, eu0_rd_1, eu1_rd_1;
    logic [31:0] data_forward00, data_forward10, data_forward01, data_forward11;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exe_forward_source dut (
        .clk(clk), .rstn(rstn), .flush(flush), .hold(hold),
        .i0_valid(i0_valid), .i1_valid(i1_valid),
        .i0_rd(i0_rd), .i1_rd(i1_rd), .i0_we(i0_we), .i1_we(i1_we),
        .i0_late(i0_late), .i1_late(i1_late),
        .i0_rj(i0_rj), .i0_rk(i0_rk), .i1_rj(i1_rj), .i1_rk(i1_rk),
        .e1_data0(e1_data0), .e1_data1(e1_data1),
        .e2_data0(e2_data0), .e2_data1(e2_data1),
        .i0_accept(i0_accept), .i1_accept(i1_accept),
        .eu0_en_0(eu0_en_0), .eu1_en_0(eu1_en_0),
        .eu0_rd_0(eu0_rd_0), .eu1_rd_0(eu1_rd_0),
        .data_forward00(data_forward00), .data_forward10(data_forward10),
        .eu0_en_1(eu0_en_1), .eu1_en_1(eu1_en_1),
        .eu0_rd_1(eu0_rd_1), .eu1_rd_1(eu1_rd_1),
        .data_forward01(data_forward01), .data_forward11(data_forward11)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        flush = 0; hold = 0;
        i0_valid = 0; i1_valid = 0; i0_we = 0; i1_we = 0; i0_late = 0; i1_late = 0;
        i0_rd = 0; i1_rd = 0; i0_rj = 0; i0_rk = 0; i1_rj = 0; i1_rk = 0;
        e1_data0 = 0; e1_data1 = 0; e2_data0 = 0; e2_data1 = 0;
    endtask

    task automatic set_i0(input logic [4:0] rd, input logic we, input logic late, input logic [31:0] d);
        i0_valid = 1; i0_rd = rd; i0_we = we; i0_late = late; e1_data0 = d;
    endtask

    task automatic set_i1(input logic [4:0] rd, input logic we, input logic late, input logic [31:0] d);
        i1_valid = 1; i1_rd = rd; i1_we = we; i1_late = late; e1_data1 = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_en_zero(input string tag);
        chk({tag, "_en00"}, {31'd0, eu0_en_0}, 32'd0);
        chk({tag, "_en10"}, {31'd0, eu1_en_0}, 32'd0);
        chk({tag, "_en01"}, {31'd0, eu0_en_1}, 32'd0);
        chk({tag, "_en11"}, {31'd0, eu1_en_1}, 32'd0);
    endtask

    initial begin
        // Reset with random inputs
        rstn = 0;
        flush = 1'($urandom); hold = 1'($urandom);
        i0_valid = 1'($urandom); i1_valid = 1'($urandom);
        i0_we = 1'($urandom); i1_we = 1'($urandom); i0_late = 1'($urandom); i1_late = 1'($urandom);
        i0_rd = 5'($urandom); i1_rd = 5'($urandom); i0_rj = 5'($urandom); i0_rk = 5'($urandom);
        i1_rj = 5'($urandom); i1_rk = 5'($urandom);
        e1_data0 = $urandom; e1_data1 = $urandom; e2_data0 = $urandom; e2_data1 = $urandom;
        repeat (2) tick();
        chk_all_en_zero("rst");
        chk("rst_df00", data_forward00, 32'h0);
        chk("rst_df10", data_forward10, 32'h0);
        chk("rst_df01", data_forward01, 32'h0);
        chk("rst_df11", data_forward11, 32'h0);
        @(negedge clk);
        idle();
        rstn = 1;

        // Basic issue and two-stage progression
        @(negedge clk);
        set_i0(5'd5, 1, 0, 32'h11);
        #1 chk("basic_acc0", {31'd0, i0_accept}, 32'd1);
        tick();
        chk("basic_en00", {31'd0, eu0_en_0}, 32'd1);
        chk("basic_rd00", {27'd0, eu0_rd_0}, 32'd5);
        chk("basic_df00", data_forward00, 32'h11);
        chk("basic_en01_early", {31'd0, eu0_en_1}, 32'd0);
        @(negedge clk);
        idle();
        tick();
        chk("basic_en01", {31'd0, eu0_en_1}, 32'd1);
        chk("basic_df01", data_forward01, 32'h11);
        chk("basic_en00_gone", {31'd0, eu0_en_0}, 32'd0);

        // Load-use stall lasts exactly one cycle
        @(negedge clk);
        set_i0(5'd7, 1, 1, 32'hDEAD);
        tick();
        @(negedge clk);
        idle();
        set_i0(5'd8, 1, 0, 32'h88);
        i0_rj = 5'd7;
        set_i1(5'd10, 1, 0, 32'hAA);
        e2_data0 = 32'hCAFE;
        #1;
        chk("lu_acc0", {31'd0, i0_accept}, 32'd0);
        chk("lu_acc1", {31'd0, i1_accept}, 32'd0);
        chk("lu_en00", {31'd0, eu0_en_0}, 32'd0);
        tick();
        chk("lu_en01", {31'd0, eu0_en_1}, 32'd1);
        chk("lu_rd01", {27'd0, eu0_rd_1}, 32'd7);
        chk("lu_df01", data_forward01, 32'hCAFE);
        chk("lu_acc0_after", {31'd0, i0_accept}, 32'd1);
        chk("lu_acc1_after", {31'd0, i1_accept}, 32'd1);
        tick();
        chk("lu_i1_en10", {31'd0, eu1_en_0}, 32'd1);
        chk("lu_i1_df10", data_forward10, 32'hAA);

        // Intra-pair RAW
        @(negedge clk);
        idle();
        set_i0(5'd3, 1, 0, 32'h33);
        set_i1(5'd4, 1, 0, 32'h44);
        i1_rk = 5'd3;
        #1;
        chk("pair_acc0", {31'd0, i0_accept}, 32'd1);
        chk("pair_acc1", {31'd0, i1_accept}, 32'd0);
        tick();
        chk("pair_en10", {31'd0, eu1_en_0}, 32'd0);
        @(negedge clk);
        set_i0(5'd12, 1, 0, 32'hC0);
        #1 chk("pair_acc1_retry", {31'd0, i1_accept}, 32'd1);
        tick();
        chk("pair_rd10", {27'd0, eu1_rd_0}, 32'd4);
        chk("pair_df10", data_forward10, 32'h44);

        // Zero register never forwards or stalls
        @(negedge clk);
        idle();
        set_i0(5'd0, 1, 1, 32'h5A);
        tick();
        chk("zero_en00", {31'd0, eu0_en_0}, 32'd0);
        @(negedge clk);
        idle();
        set_i0(5'd1, 1, 0, 32'h1);
        e2_data0 = 32'h77;
        #1 chk("zero_acc0", {31'd0, i0_accept}, 32'd1);
        tick();
        chk("zero_en01", {31'd0, eu0_en_1}, 32'd0);

        // Both EUs write the same rd
        @(negedge clk);
        idle();
        set_i0(5'd9, 1, 0, 32'h1);
        set_i1(5'd9, 1, 0, 32'h2);
        #1 chk("dual_acc1", {31'd0, i1_accept}, 32'd1);
        tick();
        chk("dual_en00", {31'd0, eu0_en_0}, 32'd1);
        chk("dual_en10", {31'd0, eu1_en_0}, 32'd1);
        chk("dual_rd10", {27'd0, eu1_rd_0}, 32'd9);
        chk("dual_df00", data_forward00, 32'h1);
        chk("dual_df10", data_forward10, 32'h2);
        @(negedge clk);
        idle();
        tick();
        chk("dual_en01", {31'd0, eu0_en_1}, 32'd1);
        chk("dual_en11", {31'd0, eu1_en_1}, 32'd1);
        chk("dual_df01", data_forward01, 32'h1);
        chk("dual_df11", data_forward11, 32'h2);

        // Hold freezes everything; flush overrides hold
        @(negedge clk);
        set_i0(5'd13, 1, 0, 32'h55);
        set_i1(5'd14, 1, 0, 32'h66);
        tick();
        @(negedge clk);
        idle();
        set_i0(5'd15, 1, 0, 32'h77);
        tick();
        @(negedge clk);
        set_i0(5'd16, 1, 0, 32'h99);
        hold = 1;
        #1 chk("hold_acc0", {31'd0, i0_accept}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("hold_en00", {31'd0, eu0_en_0}, 32'd1);
            chk("hold_rd00", {27'd0, eu0_rd_0}, 32'd15);
            chk("hold_df00", data_forward00, 32'h77);
            chk("hold_en10", {31'd0, eu1_en_0}, 32'd0);
            chk("hold_df01", data_forward01, 32'h55);
            chk("hold_df11", data_forward11, 32'h66);
            chk("hold_en11", {31'd0, eu1_en_1}, 32'd1);
        end
        @(negedge clk);
        flush = 1;
        tick();
        chk_all_en_zero("flush");

        // Asynchronous reset in the middle of a cycle
        @(negedge clk);
        idle();
        set_i0(5'd20, 1, 0, 32'h20);
        tick();
        chk("arst_pre_en00", {31'd0, eu0_en_0}, 32'd1);
        #2 rstn = 0;
        #1;
        chk_all_en_zero("arst");
        chk("arst_df00", data_forward00, 32'h0);
        @(negedge clk);
        rstn = 1;
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
